// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock,
// with start/busy/done handshake, held result, leading-zero blanking and
// overflow saturation.
module bin2bcd_seq #(
  parameter int unsigned IN_W     = 14,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);

  // Largest value representable in DIGITS decimal digits, 32-bit arithmetic.
  function automatic logic [31:0] max_dec(input int unsigned n);
    logic [31:0] p;
    p = 32'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p - 32'd1;
  endfunction

  localparam logic [31:0] MAX_VAL = max_dec(DIGITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_q;
  logic [IN_W-1:0]    src_q;
  logic [BCD_W-1:0]   bcd_s_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_s_q;
  logic               busy_q;
  logic               done_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;

  logic [BCD_W-1:0]   adj_d;
  logic [BCD_W-1:0]   bcd_s_d;
  logic [IN_W-1:0]    src_d;
  logic [BCD_W-1:0]   blank_d;
  logic               ovf_in_d;

  // Add 3 to every scratch digit >= 5, then shift {bcd_s, src} left by one.
  always_comb begin : add3_shift
    logic [3:0] dig;
    adj_d = bcd_s_q;
    dig   = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig = bcd_s_q[4*i +: 4];
      adj_d[4*i +: 4] = (dig >= 4'd5) ? (dig + 4'd3) : dig;
    end
    bcd_s_d = {adj_d[BCD_W-2:0], src_q[IN_W-1]};
    src_d   = src_q << 1;
  end

  // Blank leading zero digits from the top down; digit 0 always shown.
  always_comb begin : blanking
    logic seen;
    blank_d = bcd_s_q;
    seen    = 1'b0;
    if (BLANK_LZ != 0) begin
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
        if (!seen && (bcd_s_q[4*i +: 4] == 4'd0)) begin
          blank_d[4*i +: 4] = 4'hF;
        end else begin
          seen = 1'b1;
        end
      end
    end
  end

  // Saturation decision taken on the accepted start edge.
  always_comb begin : ovf_check
    ovf_in_d = (32'(value) > MAX_VAL);
  end

  // Control FSM and all registered state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      bcd_s_q <= '0;
      cnt_q   <= '0;
      ovf_s_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= {DIGITS{4'hF}};
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            src_q   <= value;
            bcd_s_q <= '0;
            cnt_q   <= CNT_W'(IN_W);
            ovf_s_q <= ovf_in_d;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_s_q <= bcd_s_d;
          src_q   <= src_d;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          if (ovf_s_q) begin
            bcd_q <= {DIGITS{4'h9}};
            ovf_q <= 1'b1;
          end else begin
            bcd_q <= blank_d;
            ovf_q <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Parametrised sequential binary-to-BCD converter for the seven-segment display path.
- Takes an IN_W-bit unsigned value and produces DIGITS packed BCD digits using shift-add-3 (double dabble), one input bit per clock.
- Replaces the fixed 4-digit, divide-by-10 converter.
- Adds an explicit start/busy/done handshake, glitch-free result holding, optional leading-zero blanking and overflow saturation.

Parameters:
- IN_W, 14, width of the binary input (legal range 1..27).
- DIGITS, 4, number of BCD output digits (legal range 1..8).
- BLANK_LZ, 1, 1 = leading zero digits output as 4'hF (blank code); 0 = leading zeros output as 4'h0.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  request a conversion of value; sampled only in IDLE.
- value  input  IN_W  unsigned binary operand; sampled on the accepted start edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd/overflow are updated.
- bcd  output  4*DIGITS  packed result; bcd[3:0] is the least significant digit, bcd[4*DIGITS-1:4*DIGITS-4] the most significant.
- overflow  output  1  the last converted value exceeded 10^DIGITS-1.

Behaviour:
- Reset (rst low at a clk edge): state=IDLE, busy=0, done=0, overflow=0, every bcd digit=4'hF; internal scratch cleared. Reset mid-conversion aborts the conversion with no done pulse.
- Clock and reset: one clock (clk); reset rst is synchronous, active-low. No other clocks, no asynchronous logic, no level-sensitive latches.
- States:
  - IDLE: waits for start.
  - SHIFT: runs exactly IN_W iterations.
  - FINISH: single cycle.
- IDLE -> SHIFT on an edge with start=1. On that edge:
  - latch value into shift register src;
  - clear scratch bcd_s;
  - load bit counter with IN_W;
  - set busy=1;
  - set ovf_s = (value > 10^DIGITS-1), with the constant computed at elaboration in 32-bit arithmetic.
- SHIFT, each cycle:
  - every 4-bit scratch digit >= 5 gets +3;
  - then {bcd_s,src} is shifted left by 1 (MSB of src enters bcd_s[0]; bits shifted out of the top of bcd_s are discarded);
  - counter decrements; at counter==1 -> FINISH.
- FINISH:
  - if ovf_s: bcd = all digits 4'h9, overflow=1;
  - else: bcd = bcd_s with blanking applied, overflow=0;
  - done=1, busy=0, then -> IDLE.
- Blanking (BLANK_LZ=1): scanning from the most significant digit, zero digits become 4'hF until the first nonzero digit. Digit 0 is never blanked, so value 0 -> F..F0. Not applied on overflow.
- Latency: start accepted on edge k; busy=1 from k; done=1 and new bcd valid after edge k+IN_W+1; busy=0 at that same edge.
- Back-to-back throughput: one conversion per IN_W+2 cycles. A start held high through FINISH is accepted on the edge after done.
- start while busy is ignored; value changes while busy have no effect.
- bcd and overflow hold the previous result for the whole conversion and change only together with done; no intermediate values are ever visible.
- done is high for exactly one cycle per completed conversion.
- Width rule: scratch bcd_s is 4*DIGITS bits. Truncation of high bits is harmless because out-of-range values are saturated via ovf_s.

Test Plan:
- Reset with rst=0 for 2 cycles, then release -> bcd=16'hFFFF, busy=0, done=0, overflow=0; no activity with start=0.
- Defaults, start with value=1234 -> busy high for 15 cycles; done pulse on the 15th edge after the start edge; bcd=16'h1234, overflow=0.
- Defaults, value=7 then value=0 (separate conversions) -> bcd=16'hFFF7 then 16'hFFF0. Repeat with BLANK_LZ=0 -> 16'h0007 and 16'h0000.
- Defaults, value=9999 -> 16'h9999, overflow=0. Then value=10000 -> 16'h9999, overflow=1. Then value=16383 -> 16'h9999, overflow=1.
- Start value=4321; pulse start with value=1111 mid-conversion; pull rst low for one cycle mid-conversion on a second run -> first run yields 16'h4321 with no second done; the reset run gives no done and bcd=16'hFFFF.
- IN_W=20, DIGITS=6: value=999999 -> 24'h999999 after 21 cycles. Hold start high continuously -> done pulses every 22 cycles.
